// File: rtl/wm_plant_sensor_model_if.sv
// Controller <-> plant bundle: actuator commands one way, sensor/timer flags the other.
// master = controller side (drives commands), slave = plant side (drives sensors).
// LEVEL_MAX must match the plant instance so the level bus width agrees.
interface wm_plant_sensor_model_if #(
  parameter int LEVEL_MAX = 8
) ();
  localparam int LW = $clog2(LEVEL_MAX + 1);

  // actuator commands from the controller
  logic          fill_value_on;
  logic          drain_value_on;
  logic          motor_on;
  logic          door_lock;
  logic          soap_wash;
  logic          water_wash;

  // plant feedback
  logic          filled;
  logic          drained;
  logic          detergent_added;
  logic          cycle_timeout;
  logic          spin_timeout;
  logic          fault;
  logic [LW-1:0] level;

  modport master (
    output fill_value_on, drain_value_on, motor_on, door_lock, soap_wash, water_wash,
    input  filled, drained, detergent_added, cycle_timeout, spin_timeout, fault, level
  );

  modport slave (
    input  fill_value_on, drain_value_on, motor_on, door_lock, soap_wash, water_wash,
    output filled, drained, detergent_added, cycle_timeout, spin_timeout, fault, level
  );
endinterface

// File: rtl/wm_plant_sensor_model.sv
// Washing-machine plant model: water level, detergent/cycle/spin timers, optional fault watchdog.
// Latency: all outputs decoded from registers; level/timers advance on the tick after a command.
// No backpressure; WM_PLANT_FAULT_EN builds the sticky fault register and fill watchdog.
module wm_plant_sensor_model #(
  parameter int TICK_DIV     = 4,
  parameter int LEVEL_MAX    = 8,
  parameter int DET_TICKS    = 3,
  parameter int CYCLE_TICKS  = 10,
  parameter int SPIN_TICKS   = 6,
  parameter int FILL_TIMEOUT = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  wm_plant_sensor_model_if.slave  bus
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LW = $clog2(LEVEL_MAX + 1);
  localparam int DW = $clog2(DET_TICKS + 1);
  localparam int CW = $clog2(CYCLE_TICKS + 1);
  localparam int SW = $clog2(SPIN_TICKS + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [LW-1:0] LEVEL_TOP = LW'(LEVEL_MAX);
  localparam logic [DW-1:0] DET_TOP   = DW'(DET_TICKS);
  localparam logic [CW-1:0] CYC_TOP   = CW'(CYCLE_TICKS);
  localparam logic [SW-1:0] SPIN_TOP  = SW'(SPIN_TICKS);

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [LW-1:0] level_q;
  logic [DW-1:0] det_cnt;
  logic [CW-1:0] cyc_cnt;
  logic [SW-1:0] spin_cnt;
  logic          filled_s;
  logic          drained_s;
  logic          det_run;
  logic          cyc_run;
  logic          spin_run;

  assign tick      = (tick_cnt == TICK_LAST);
  assign filled_s  = (level_q == LEVEL_TOP);
  assign drained_s = (level_q == '0);

  // Run conditions use only registered level flags plus commands; door_lock gates all timers.
  assign det_run  = bus.soap_wash & ~bus.water_wash & filled_s & ~bus.motor_on &
                    ~bus.fill_value_on & ~bus.drain_value_on & bus.door_lock;
  assign cyc_run  = bus.motor_on & bus.door_lock;
  assign spin_run = bus.drain_value_on & drained_s & bus.door_lock;

  // Free-running tick prescaler; phase restarts at reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TW'(1);
  end

  // Water level: one count per tick toward the open valve, saturating; both/neither valves hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_q <= '0;
    end else if (tick) begin
      if (bus.fill_value_on && !bus.drain_value_on && level_q != LEVEL_TOP)
        level_q <= level_q + LW'(1);
      else if (bus.drain_value_on && !bus.fill_value_on && level_q != '0)
        level_q <= level_q - LW'(1);
    end
  end

  // Detergent dispense timer: clears the clk after its condition drops, saturates at threshold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                           det_cnt <= '0;
    else if (!det_run)                    det_cnt <= '0;
    else if (tick && det_cnt != DET_TOP)  det_cnt <= det_cnt + DW'(1);
  end

  // Motor run timer: restarts whenever the motor or door lock drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                           cyc_cnt <= '0;
    else if (!cyc_run)                    cyc_cnt <= '0;
    else if (tick && cyc_cnt != CYC_TOP)  cyc_cnt <= cyc_cnt + CW'(1);
  end

  // Spin timer: counts only once the drum is empty and still draining.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                            spin_cnt <= '0;
    else if (!spin_run)                    spin_cnt <= '0;
    else if (tick && spin_cnt != SPIN_TOP) spin_cnt <= spin_cnt + SW'(1);
  end

  assign bus.level           = level_q;
  assign bus.filled          = filled_s;
  assign bus.drained         = drained_s;
  assign bus.detergent_added = (det_cnt == DET_TOP);
  assign bus.cycle_timeout   = (cyc_cnt == CYC_TOP);
  assign bus.spin_timeout    = (spin_cnt == SPIN_TOP);

`ifdef WM_PLANT_FAULT_EN
  localparam int FW = $clog2(FILL_TIMEOUT + 1);
  localparam logic [FW-1:0] FILL_TOP  = FW'(FILL_TIMEOUT);
  localparam logic [FW-1:0] FILL_LAST = FW'(FILL_TIMEOUT - 1);

  logic [FW-1:0] fill_wd;
  logic          fault_q;

  // Fill watchdog: ticks of uninterrupted filling that have not yet reached a full drum.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                              fill_wd <= '0;
    else if (!bus.fill_value_on || filled_s) fill_wd <= '0;
    else if (tick && fill_wd != FILL_TOP)    fill_wd <= fill_wd + FW'(1);
  end

  // Sticky fault: both valves open at a tick, or the watchdog reaching its limit on this tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      fault_q <= 1'b0;
    else if (tick && bus.fill_value_on &&
             (bus.drain_value_on || (!filled_s && fill_wd == FILL_LAST)))
      fault_q <= 1'b1;
  end

  assign bus.fault = fault_q;
`else
  // Feature absent: fault is constant 0 (FILL_TIMEOUT is only meaningful with the watchdog).
  assign bus.fault = 1'b0 && (FILL_TIMEOUT > 0);
`endif
endmodule

// File: tb/tb_wm_plant_sensor_model.sv
// Closed-loop bench for the plant model: directed test-plan phases then random command bursts.
// A behavioural model pushes expected outputs per clock; a monitor pops and compares.
// Async reset is checked directly between clock edges.
module tb_wm_plant_sensor_model;
  localparam int TD = 2;
  localparam int LM = 4;
  localparam int DT = 3;
  localparam int CT = 10;
  localparam int ST = 6;
  localparam int FT = 8;
  localparam int LW = $clog2(LM + 1);

  localparam logic [5:0] F = 6'b100000;
  localparam logic [5:0] D = 6'b010000;
  localparam logic [5:0] M = 6'b001000;
  localparam logic [5:0] L = 6'b000100;
  localparam logic [5:0] S = 6'b000010;
  localparam logic [5:0] W = 6'b000001;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  wm_plant_sensor_model_if #(.LEVEL_MAX(LM)) bus ();

  wm_plant_sensor_model #(
    .TICK_DIV(TD), .LEVEL_MAX(LM), .DET_TICKS(DT),
    .CYCLE_TICKS(CT), .SPIN_TICKS(ST), .FILL_TIMEOUT(FT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          filled;
    logic          drained;
    logic          det;
    logic          cyc;
    logic          spin;
    logic          fault;
    logic [LW-1:0] level;
  } obs_t;

  obs_t exp_q[$];

  // Reference state in plain integers: elapsed ticks per timer, level in counts.
  int m_phase = 0, m_level = 0, m_det = 0, m_cyc = 0, m_spin = 0, m_wd = 0;
  bit m_fault = 1'b0;

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.filled  = (m_level == LM);
    o.drained = (m_level == 0);
    o.det     = (m_det >= DT);
    o.cyc     = (m_cyc >= CT);
    o.spin    = (m_spin >= ST);
    o.fault   = m_fault;
    o.level   = LW'(m_level);
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_obs(input string tag, input obs_t e);
    check({tag, "_level"},   32'(bus.level),           32'(e.level));
    check({tag, "_filled"},  32'(bus.filled),          32'(e.filled));
    check({tag, "_drained"}, 32'(bus.drained),         32'(e.drained));
    check({tag, "_det"},     32'(bus.detergent_added), 32'(e.det));
    check({tag, "_cycle"},   32'(bus.cycle_timeout),   32'(e.cyc));
    check({tag, "_spin"},    32'(bus.spin_timeout),    32'(e.spin));
    check({tag, "_fault"},   32'(bus.fault),           32'(e.fault));
  endtask

  // Behavioural model: advances one clock, pushes the expected outputs after that edge.
  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_phase = 0; m_level = 0; m_det = 0; m_cyc = 0; m_spin = 0; m_wd = 0;
        m_fault = 1'b0;
      end else begin
        bit tk, fl, dr, mo, lk, so, wa, full, empty;
        fl = bus.fill_value_on; dr = bus.drain_value_on; mo = bus.motor_on;
        lk = bus.door_lock;     so = bus.soap_wash;      wa = bus.water_wash;
        tk = (m_phase == TD - 1);
        m_phase = (m_phase + 1) % TD;
        full  = (m_level == LM);
        empty = (m_level == 0);
        m_det  = (so && !wa && full && !mo && !fl && !dr && lk) ? min2(m_det + int'(tk), DT) : 0;
        m_cyc  = (mo && lk) ? min2(m_cyc + int'(tk), CT) : 0;
        m_spin = (dr && empty && lk) ? min2(m_spin + int'(tk), ST) : 0;
`ifdef WM_PLANT_FAULT_EN
        if (tk && fl && dr) m_fault = 1'b1;
        if (!fl || full) m_wd = 0;
        else if (tk) begin
          m_wd = min2(m_wd + 1, FT);
          if (m_wd == FT) m_fault = 1'b1;
        end
`endif
        if (tk) begin
          if (fl && !dr)      m_level = min2(m_level + 1, LM);
          else if (dr && !fl) m_level = (m_level > 0) ? m_level - 1 : 0;
        end
        exp_q.push_back(model_obs());
      end
    end
  end

  // Monitor: after every active edge outside reset, pop one expectation and compare.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (reset) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_underflow got=empty exp=entry at %0t", $time);
        end else begin
          check_obs("mon", exp_q.pop_front());
        end
      end
    end
  end

  // Apply one command vector at a falling edge and hold it for ncyc clocks.
  task automatic drive(input logic [5:0] v, input int ncyc);
    {bus.fill_value_on, bus.drain_value_on, bus.motor_on,
     bus.door_lock, bus.soap_wash, bus.water_wash} = v;
    repeat (ncyc) @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_level"},   32'(bus.level),           32'd0);
    check({tag, "_drained"}, 32'(bus.drained),         32'd1);
    check({tag, "_filled"},  32'(bus.filled),          32'd0);
    check({tag, "_det"},     32'(bus.detergent_added), 32'd0);
    check({tag, "_cycle"},   32'(bus.cycle_timeout),   32'd0);
    check({tag, "_spin"},    32'(bus.spin_timeout),    32'd0);
    check({tag, "_fault"},   32'(bus.fault),           32'd0);
  endtask

  initial begin
    logic [5:0] v;
    {bus.fill_value_on, bus.drain_value_on, bus.motor_on,
     bus.door_lock, bus.soap_wash, bus.water_wash} = 6'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("por");
    reset = 1'b1;

    drive(6'b0, 4);
    drive(F, 2 * 6);               // fill to LEVEL_MAX and hold at saturation
    drive(D | L, 2 * 12);          // drain to empty, then spin runs to its timeout
    drive(L, 2);                   // drain off: spin timeout drops
    drive(M | L, 2 * 12);          // full motor run to cycle_timeout
    drive(M | L, 2 * 5);           // partial run ...
    drive(L, 1);                   // ... interrupted, count restarts
    drive(M | L, 2 * 12);
    drive(F, 2 * 5);               // refill
    drive(S | L, 2 * 5);           // detergent dispense
    drive(S | W | L, 2 * 5);       // rinse flag blocks dispense
    drive(S, 2 * 5);               // door unlocked blocks dispense
    drive(D, 2 * 5);               // unlocked drain still moves level
    drive(F | M | L, 4);           // level 2, cycle timer running
    drive(M | L, 5);               // cycle timer about half way

    // Async reset between edges: outputs must clear before the next clock edge.
    #2;
    reset = 1'b0;
    #1;
    check_reset_state("async_rst");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    drive(F | D, 2);               // both valves for one tick
    drive(6'b0, 4);
    drive(F | D | L, 2 * 9);       // fill held past FILL_TIMEOUT with drain open
    drive(6'b0, 4);

    for (int i = 0; i < 400; i++) begin
      v = 6'($urandom);
      v[2] = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) v[5:4] = 2'b11;
      drive(v, int'($urandom_range(1, 10)));
    end

    drive(6'b0, 4);
    @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
